// File: rtl/activation_pkg.sv
// rtl/activation_pkg.sv - shared mode encodings and clamp helper for activation_pipe
//
// Contents:
//   MODE_CLIP / MODE_TANH / MODE_LEAKY : run-time mode encodings (3 is reserved, acts as clip)
//   clamp_signed(v, w, sat)            : clamp a signed value to a w-bit signed range
package activation_pkg;

  localparam logic [1:0] MODE_CLIP  = 2'd0;
  localparam logic [1:0] MODE_TANH  = 2'd1;
  localparam logic [1:0] MODE_LEAKY = 2'd2;

  // Working width of the clamp helper; callers sign-extend into it and
  // truncate the result back to their own output width.
  localparam int CLAMP_W = 64;

  // Clamp v into [-2^(w-1), 2^(w-1)-1]. sat is set only when v lies strictly
  // outside that range, so the boundary values themselves are not counted.
  function automatic logic signed [CLAMP_W-1:0] clamp_signed(
    input  logic signed [CLAMP_W-1:0] v,
    input  int                        w,
    output logic                      sat
  );
    logic signed [CLAMP_W-1:0] hi;
    logic signed [CLAMP_W-1:0] lo;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    sat = 1'b0;
    if (v > hi) begin
      sat = 1'b1;
      return hi;
    end
    if (v < lo) begin
      sat = 1'b1;
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/activation_lane.sv
// rtl/activation_lane.sv - single-channel activation: pre-clamp shaping plus output clamp
//
// Ports:
//   mode   in   2        activation mode for x
//   x      in   IN_W     signed channel input
//   pre    out  IN_W+1   shaped value before clamp (registered by the parent)
//   pre_q  in   IN_W+1   registered shaped value to clamp
//   y      out  OUT_W    clamped result of pre_q
//   sat    out  1        pre_q was outside the OUT_W signed range
//
// Purely combinational; the parent places the pipeline register between
// pre and pre_q.
module activation_lane
  import activation_pkg::*;
#(
  parameter int IN_W       = 17,
  parameter int OUT_W      = 16,
  parameter int KNEE       = 16384,
  parameter int TANH_SHIFT = 2,
  parameter int LEAK_SHIFT = 3
) (
  input  logic [1:0]         mode,
  input  logic signed [IN_W-1:0] x,
  output logic signed [IN_W:0]   pre,
  input  logic signed [IN_W:0]   pre_q,
  output logic [OUT_W-1:0]   y,
  output logic               sat
);

  localparam logic signed [IN_W:0] KNEE_S = (IN_W + 1)'(KNEE);

  logic signed [IN_W:0]         xe;
  logic signed [IN_W:0]         diff;
  logic signed [CLAMP_W-1:0]    pre_ext;

  // One extra bit of headroom so the knee arithmetic never overflows.
  assign xe = {x[IN_W-1], x};

  always_comb begin
    diff = '0;
    pre  = xe;
    case (mode)
      MODE_TANH: begin
        if (xe > KNEE_S) begin
          diff = xe - KNEE_S;
          pre  = KNEE_S + (diff >>> TANH_SHIFT);
        end else if (xe < -KNEE_S) begin
          diff = xe + KNEE_S;
          pre  = (diff >>> TANH_SHIFT) - KNEE_S;
        end
      end
      MODE_LEAKY: begin
        // Arithmetic shift floors toward minus infinity, so -1 stays -1.
        if (xe[IN_W]) begin
          pre = xe >>> LEAK_SHIFT;
        end
      end
      default: begin
        pre = xe;
      end
    endcase
  end

  assign pre_ext = {{(CLAMP_W - IN_W - 1){pre_q[IN_W]}}, pre_q};

  always_comb begin
    sat = 1'b0;
    y   = OUT_W'(clamp_signed(pre_ext, OUT_W, sat));
  end

endmodule

// File: rtl/activation_pipe.sv
// rtl/activation_pipe.sv - CH-channel, 2-stage pipelined saturating activation with saturation counter
//
// Ports:
//   clk        in   1         clock, rising edge
//   rst_n      in   1         asynchronous reset, active low
//   in_valid   in   1         input beat valid
//   in_ready   out  1         unit can accept a beat
//   in_data    in   CH*IN_W   packed signed inputs, channel 0 in LSBs
//   in_mode    in   2         0 clip, 1 piecewise tanh, 2 leaky ReLU, 3 acts as clip
//   out_valid  out  1         output beat valid
//   out_ready  in   1         downstream accepts
//   out_data   out  CH*OUT_W  packed signed results, channel 0 in LSBs
//   sat_cnt    out  CNT_W     clamped channel results since last clear (saturating)
//   sat_clr    in   1         synchronous clear of sat_cnt
module activation_pipe
  import activation_pkg::*;
#(
  parameter int CH         = 4,
  parameter int IN_W       = 17,
  parameter int OUT_W      = 16,
  parameter int KNEE       = 16384,
  parameter int TANH_SHIFT = 2,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*IN_W-1:0]    in_data,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*OUT_W-1:0]   out_data,
  output logic [CNT_W-1:0]      sat_cnt,
  input  logic                  sat_clr
);

  localparam int NW = $clog2(CH + 1);
  localparam int SW = CNT_W + NW;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

  logic                   adv;
  logic                   fire;
  logic                   v1;
  logic signed [IN_W:0]   pre_c [CH];
  logic signed [IN_W:0]   pre_q [CH];
  logic [CH*OUT_W-1:0]    y_c;
  logic [CH-1:0]          sat_c;
  logic [NW-1:0]          nsat_c;
  logic [NW-1:0]          nsat_q;
  logic [SW-1:0]          cnt_base;
  logic [SW-1:0]          cnt_sum;

  // Single global advance: every stage moves together or holds together.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign fire     = out_valid && out_ready;

  for (genvar g = 0; g < CH; g++) begin : g_lane
    activation_lane #(
      .IN_W       (IN_W),
      .OUT_W      (OUT_W),
      .KNEE       (KNEE),
      .TANH_SHIFT (TANH_SHIFT),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .mode  (in_mode),
      .x     (in_data[g*IN_W +: IN_W]),
      .pre   (pre_c[g]),
      .pre_q (pre_q[g]),
      .y     (y_c[g*OUT_W +: OUT_W]),
      .sat   (sat_c[g])
    );
  end

  always_comb begin
    nsat_c = '0;
    for (int i = 0; i < CH; i++) begin
      nsat_c = nsat_c + NW'(sat_c[i]);
    end
  end

  // S1 holds shaped values, S2 holds clamped results plus the number of
  // clamped channels so the counter can charge them when the beat leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      nsat_q    <= '0;
      for (int i = 0; i < CH; i++) begin
        pre_q[i] <= '0;
      end
    end else if (adv) begin
      v1        <= in_valid;
      out_valid <= v1;
      out_data  <= y_c;
      nsat_q    <= nsat_c;
      for (int i = 0; i < CH; i++) begin
        pre_q[i] <= pre_c[i];
      end
    end
  end

  // Clear wins over the old value but not over a same-cycle increment.
  always_comb begin
    cnt_base = sat_clr ? '0 : SW'(sat_cnt);
    cnt_sum  = cnt_base + (fire ? SW'(nsat_q) : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (sat_clr || fire) begin
      sat_cnt <= (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_activation_pipe.sv
// tb/tb_activation_pipe.sv - scoreboard testbench for activation_pipe
module tb_activation_pipe;

  localparam int CH    = 4;
  localparam int IN_W  = 17;
  localparam int OUT_W = 16;
  localparam int DW    = CH * OUT_W;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic [CH*IN_W-1:0]   in_data = '0;
  logic [1:0]           in_mode = 2'd0;
  logic                 out_ready = 1'b1;
  logic                 sat_clr = 1'b0;
  logic                 in_ready, out_valid;
  logic [DW-1:0]        out_data;
  logic [15:0]          sat_cnt;
  logic                 in_ready_s, out_valid_s;
  logic [DW-1:0]        out_data_s;
  logic [3:0]           sat_cnt_s;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] sb[$];
  bit            bp_en = 1'b0;

  activation_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
  );

  activation_pipe #(.CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .sat_cnt(sat_cnt_s), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [CH*IN_W-1:0] pk_in(input int a, input int b, input int c, input int d);
    logic [IN_W-1:0] la, lb, lc, ld;
    la = IN_W'(a); lb = IN_W'(b); lc = IN_W'(c); ld = IN_W'(d);
    return {ld, lc, lb, la};
  endfunction

  function automatic logic [DW-1:0] pk_out(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Downstream ready changes 2 time units after the edge, so the driver's
  // negedge look at in_ready sees the value that the next edge will use.
  initial forever begin
    @(posedge clk);
    #2;
    out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on each output handshake, watches hold
  // stability under stall, and cross-checks the small-counter twin.
  initial begin : monitor
    logic          stall_q;
    logic [DW-1:0] held;
    logic [DW-1:0] exp;
    stall_q = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          n_cmp++;
          if (!out_valid || out_data !== held) begin
            n_bad++;
            $display("FAIL hold: got v=%0b data=%h expected v=1 data=%h", out_valid, out_data, held);
          end
        end
        if (out_valid_s !== out_valid || in_ready_s !== in_ready ||
            (out_valid && out_data_s !== out_data)) begin
          n_cmp++;
          n_bad++;
          $display("FAIL twin: got v=%0b d=%h expected v=%0b d=%h", out_valid_s, out_data_s, out_valid, out_data);
        end
        if (out_valid && out_ready) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_beat: got %h expected none", out_data);
          end else begin
            exp = sb.pop_front();
            if (out_data !== exp) begin
              n_bad++;
              $display("FAIL beat: got %h expected %h", out_data, exp);
            end
          end
        end
        stall_q = out_valid && !out_ready;
        held    = out_data;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  // with in_valid still high so consecutive calls stream back-to-back.
  task automatic send(input logic [1:0] m, input logic [CH*IN_W-1:0] d, input logic [DW-1:0] e);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    n        = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sb.push_back(e);
        break;
      end
      n++;
      if (n > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Single beat into an idle pipe with cycle-exact latency checks.
  task automatic lat_beat(input logic [1:0] m, input logic [CH*IN_W-1:0] d, input logic [DW-1:0] e);
    check("lat_ready", DW'(in_ready), DW'(1));
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", DW'(out_valid), DW'(0));
    @(posedge clk);
    @(negedge clk);
    check("lat_cycle2_valid", DW'(out_valid), DW'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_sat_cnt", DW'(sat_cnt), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", DW'(in_ready), DW'(1));

    // Clip with latency, then the mode table
    lat_beat(2'd0, pk_in(32768, -32769, 'h1234, 32767), pk_out(16'h7FFF, 16'h8000, 16'h1234, 16'h7FFF));
    send(2'd1, pk_in('h6000, -'h6000, 65535, 'h4000), pk_out(16'h4800, 16'hB800, 16'h6FFF, 16'h4000));
    send(2'd3, pk_in(40000, -40000, 0, 32767), pk_out(16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF));
    send(2'd2, pk_in(-256, -65536, -1, 1000), pk_out(16'hFFE0, 16'hE000, 16'hFFFF, 16'h03E8));
    send(2'd0, pk_in(-32768, 32767, 65535, -65536), pk_out(16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000));
    send(2'd1, pk_in(16385, -16385, -16384, -65536), pk_out(16'h4000, 16'hBFFF, 16'hC000, 16'h9000));
    drain();
    check("sat_after_modes", DW'(sat_cnt), DW'(6));
    check("sat_small_after_modes", DW'(sat_cnt_s), DW'(6));

    // Backpressure stream
    bp_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(2'd0, pk_in(i*257, i*257 + 4096, i*257 + 8192, i*257 + 12288),
           pk_out(16'(i*257), 16'(i*257 + 4096), 16'(i*257 + 8192), 16'(i*257 + 12288)));
    end
    drain();
    bp_en = 1'b0;
    @(posedge clk);
    #1;
    check("sat_after_bp", DW'(sat_cnt), DW'(6));

    // Counter
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    check("sat_clear_idle", DW'(sat_cnt), DW'(0));
    for (int i = 0; i < 4; i++) begin
      send(2'd0, pk_in(40000, -40000, 65535, -65536), pk_out(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000));
    end
    drain();
    check("sat_16", DW'(sat_cnt), DW'(16));
    check("sat_small_hold_15", DW'(sat_cnt_s), DW'(15));
    send(2'd0, pk_in(40000, -40000, 65535, -65536), pk_out(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000));
    drain();
    check("sat_20", DW'(sat_cnt), DW'(20));
    check("sat_small_20_held", DW'(sat_cnt_s), DW'(15));

    in_valid = 1'b1;
    in_mode  = 2'd0;
    in_data  = pk_in(40000, -40000, 5, -5);
    sb.push_back(pk_out(16'h7FFF, 16'h8000, 16'h0005, 16'hFFFB));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("clr_pre_valid", DW'(out_valid), DW'(1));
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    check("sat_clr_with_fire", DW'(sat_cnt), DW'(2));
    check("sat_small_clr_with_fire", DW'(sat_cnt_s), DW'(2));

    // Reset mid-stream with two beats in flight
    send(2'd0, pk_in(100, 200, 300, 400), pk_out(16'd100, 16'd200, 16'd300, 16'd400));
    send(2'd0, pk_in(-100, -200, 40000, 1), pk_out(16'hFF9C, 16'hFF38, 16'h7FFF, 16'h0001));
    in_valid = 1'b0;
    check("pre_rst_valid", DW'(out_valid), DW'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", DW'(out_valid), DW'(0));
    check("midrst_sat_cnt", DW'(sat_cnt), DW'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", DW'(in_ready), DW'(1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_beat", DW'(out_valid), DW'(0));
    end
    @(posedge clk);
    #1;
    lat_beat(2'd2, pk_in(-8, -9, 7, 40000), pk_out(16'hFFFF, 16'hFFFE, 16'h0007, 16'h7FFF));
    drain();
    check("sb_empty_end", DW'(sb.size()), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/activation_pipe.md
Name: activation_pipe

Overview:
- Parametrised, pipelined successor to the single-channel combinational saturating activation used in the reservoir datapath.
- Processes CH channels per beat under valid/ready flow control.
- Run-time mode select: hard clip, 3-segment piecewise-linear tanh, or leaky ReLU. All modes finish with a signed clamp to OUT_W bits.
- Sits between the reservoir accumulator (IN_W-wide sums) and the state memory / readout. Keeps a saturation-event counter used for gain tuning.

Parameters:
- CH, 4, channels processed in parallel per beat
- IN_W, 17, signed input width per channel
- OUT_W, 16, signed output width per channel; OUT_W < IN_W required
- KNEE, 16384, piecewise-tanh knee (positive, < 2^(OUT_W-1))
- TANH_SHIFT, 2, slope beyond knee = 2^-TANH_SHIFT
- LEAK_SHIFT, 3, negative-side slope in leaky mode = 2^-LEAK_SHIFT
- CNT_W, 16, saturation counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat
- in_data  in  CH*IN_W  packed signed inputs, channel 0 in LSBs
- in_mode  in  2  0 = clip, 1 = piecewise tanh, 2 = leaky ReLU, 3 = reserved (behaves as 0); sampled with the beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  CH*OUT_W  packed signed results, channel 0 in LSBs
- sat_cnt  out  CNT_W  number of channel results clamped since last clear
- sat_clr  in  1  synchronous clear of sat_cnt

Behaviour:
- Reset (rst_n low, asynchronous): all valid bits 0, out_data 0, sat_cnt 0, internal pipe registers 0. in_ready is 1 from the first cycle after reset is released. Reset mid-operation discards in-flight beats; no partial output appears.
- Pipeline has 2 register stages.
  - S1 registers the pre-clamp value p (IN_W+1 bits, sign-extended) and mode.
  - S2 registers the clamped result and drives out_data.
- Latency: 2 cycles from accepted beat to out_valid when unstalled. Throughput is 1 beat per cycle.
- Flow control:
  - Global advance: adv = !out_valid || out_ready.
  - in_ready = adv. A beat is accepted when in_valid && in_ready.
  - While stalled, S1 and S2 hold their contents and out_data stays stable. No beat is lost or duplicated.
  - Bubbles propagate as valid = 0.
- Per-channel arithmetic (x signed IN_W):
  - clip: p = x.
  - tanh: if x > KNEE, p = KNEE + ((x - KNEE) >>> TANH_SHIFT). If x < -KNEE, p = -KNEE + ((x + KNEE) >>> TANH_SHIFT). Otherwise p = x.
  - leaky: if x >= 0, p = x; else p = x >>> LEAK_SHIFT (arithmetic shift, floor).
  - clamp (S2):
    - p > 2^(OUT_W-1)-1 gives 0x7FFF
    - p < -2^(OUT_W-1) gives 0x8000
    - otherwise y = p[OUT_W-1:0]
  - The clamp boundary values themselves do not count as saturated; only values strictly outside the range do.
- sat_cnt:
  - Counts clamped channels only in beats leaving S2 with out_valid && out_ready. It adds 0..CH per handshake.
  - Saturates at 2^CNT_W - 1; no wrap.
  - sat_clr has priority over the old value. If sat_clr coincides with a counting handshake, the result equals that handshake's increment.

Decomposition:
- Shared package activation_pkg holds:
  - mode encoding constants MODE_CLIP, MODE_TANH, MODE_LEAKY
  - helper function clamp_signed, width-parameterised
- One natural sub-module: activation_lane (single channel). It holds the combinational pre-clamp function of mode and x, plus the clamp and saturation flag. It is instantiated CH times by a generate loop. Pipeline registers, handshake and counter live in the top.

Test Plan:
- Clip, default params:
  - x = +32768 gives 0x7FFF, sat +1
  - x = -32769 gives 0x8000, sat +1
  - x = 0x1234 gives 0x1234, sat +0
  - x = 32767 gives 0x7FFF, not counted
  - out_valid exactly 2 cycles after acceptance
- Tanh:
  - x = 0x6000 gives 0x4800
  - x = -0x6000 gives 0xB800
  - x = 65535 gives 0x6FFF
  - x = 0x4000 gives 0x4000
  - mode 3 with x = 40000 gives 0x7FFF
- Leaky:
  - x = -256 gives 0xFFE0
  - x = -65536 gives 0xE000
  - x = -1 gives 0xFFFF
  - x = 1000 gives 0x03E8
- Backpressure:
  - Stream 10 beats with in_valid always 1 and out_ready toggling pseudo-randomly.
  - Output sequence must equal the scoreboard in order with no drops or duplicates.
  - out_data must stay stable while out_valid && !out_ready.
- Counter:
  - Four beats, each with all 4 channels saturating, give sat_cnt = 16.
  - sat_clr asserted in the same cycle as a handshake with 2 saturating channels gives sat_cnt = 2.
  - With CNT_W = 4, forcing 20 saturations holds sat_cnt at 15.
- Reset mid-stream:
  - Assert rst_n low asynchronously with two beats in flight.
  - out_valid drops immediately and sat_cnt = 0.
  - After release no stale beat emerges, and the next accepted beat appears 2 cycles later.
